// File: rtl/f1_tick_delay.sv
// f1_tick_delay: step-tick generator and random-hold timer for a light FSM.
//
// A free-running 7-bit LFSR (x^7+x^3+1, seed 7'h01) supplies a pseudo-random
// hold length. A down-counter produces one tick_i every n+1 cycles while either
// the light sequence is requested (cmd_seq) or a hold is running. A rising edge
// of cmd_delay captures the LFSR value K and the hold then lasts K ticks,
// ending with a one-cycle time_out pulse.
//
// Ports:
//   clk        in   single clock, all state changes on posedge
//   rst        in   synchronous, active-high reset
//   cmd_seq    in   request to run the light-step tick
//   cmd_delay  in   request for a random hold; rising edge starts it
//   n          in   tick period minus one, in clk cycles (N_WIDTH bits)
//   tick       out  one-cycle step pulse (tick_i gated by cmd_seq)
//   time_out   out  one-cycle pulse at end of a hold
//   delay_busy out  high while a hold runs
//   lfsr_out   out  current LFSR state
module f1_tick_delay #(
    parameter int unsigned N_WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_seq,
    input  logic               cmd_delay,
    input  logic [N_WIDTH-1:0] n,
    output logic               tick,
    output logic               time_out,
    output logic               delay_busy,
    output logic [6:0]         lfsr_out
);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        DONE
    } state_t;

    state_t             state;
    logic [6:0]         lfsr;
    logic [N_WIDTH-1:0] count;
    logic               tick_i;
    logic               cmd_delay_q;
    logic               edge_arm;
    logic [6:0]         dcount;
    logic               active;
    logic               delay_rise;

    assign active   = cmd_seq | (state == DELAY);
    assign tick     = tick_i & cmd_seq;
    assign lfsr_out = lfsr;

    // cmd_delay_q clears in reset, so a level held high through reset would
    // look like a rising edge on the first cycle out of reset. edge_arm masks
    // edge detection for that one cycle while cmd_delay_q picks up the level.
    assign delay_rise = cmd_delay & ~cmd_delay_q & edge_arm;

    // Free-running LFSR; the all-zero state is unreachable from the seed.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 7'h01;
        end else begin
            lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[2]};
        end
    end

    // Tick down-counter. n is only sampled on reload, so a change of n
    // mid-count takes effect at the next period.
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= n;
            tick_i <= 1'b0;
        end else if (active) begin
            if (count == '0) begin
                count  <= n;
                tick_i <= 1'b1;
            end else begin
                count  <= count - 1'b1;
                tick_i <= 1'b0;
            end
        end else begin
            count  <= n;
            tick_i <= 1'b0;
        end
    end

    // Hold FSM with registered outputs; time_out mirrors DONE and delay_busy
    // mirrors DELAY, both updated on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            dcount      <= '0;
            cmd_delay_q <= 1'b0;
            edge_arm    <= 1'b0;
            time_out    <= 1'b0;
            delay_busy  <= 1'b0;
        end else begin
            cmd_delay_q <= cmd_delay;
            edge_arm    <= 1'b1;
            case (state)
                IDLE: begin
                    time_out <= 1'b0;
                    if (delay_rise) begin
                        dcount     <= lfsr;
                        state      <= DELAY;
                        delay_busy <= 1'b1;
                    end else begin
                        delay_busy <= 1'b0;
                    end
                end
                DELAY: begin
                    if (tick_i) begin
                        dcount <= dcount - 1'b1;
                        if (dcount == 7'd1) begin
                            state      <= DONE;
                            delay_busy <= 1'b0;
                            time_out   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    time_out   <= 1'b0;
                    delay_busy <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    time_out   <= 1'b0;
                    delay_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_f1_tick_delay.sv
// Directed testbench for f1_tick_delay. Inputs change 1 time unit after each
// rising edge; outputs are sampled at the same point. Step i in a loop means
// "the i-th rising edge after the reference edge".
module tb_f1_tick_delay;

    localparam int unsigned NW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_seq;
    logic          cmd_delay;
    logic [NW-1:0] n;
    logic          tick;
    logic          time_out;
    logic          delay_busy;
    logic [6:0]    lfsr_out;

    int unsigned tests  = 0;
    int unsigned failed = 0;

    logic [6:0] lfsr_exp [7];

    always #5 clk = ~clk;

    f1_tick_delay #(.N_WIDTH(NW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_seq    (cmd_seq),
        .cmd_delay  (cmd_delay),
        .n          (n),
        .tick       (tick),
        .time_out   (time_out),
        .delay_busy (delay_busy),
        .lfsr_out   (lfsr_out)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Two reset edges; afterwards lfsr_out is 7'h01 and all commands are low.
    task automatic do_reset(input logic [NW-1:0] nv);
        rst       = 1'b1;
        n         = nv;
        cmd_seq   = 1'b0;
        cmd_delay = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        lfsr_exp[0] = 7'h01;
        lfsr_exp[1] = 7'h02;
        lfsr_exp[2] = 7'h04;
        lfsr_exp[3] = 7'h09;
        lfsr_exp[4] = 7'h12;
        lfsr_exp[5] = 7'h24;
        lfsr_exp[6] = 7'h49;

        // Reset state and LFSR sequence / period.
        do_reset(16'd3);
        check("rst_tick", {31'd0, tick}, 32'd0);
        check("rst_time_out", {31'd0, time_out}, 32'd0);
        check("rst_busy", {31'd0, delay_busy}, 32'd0);
        check("rst_lfsr", {25'd0, lfsr_out}, 32'h01);
        for (int i = 1; i <= 6; i++) begin
            step();
            check("lfsr_seq", {25'd0, lfsr_out}, {25'd0, lfsr_exp[i]});
        end
        for (int i = 7; i <= 127; i++) begin
            step();
        end
        check("lfsr_period", {25'd0, lfsr_out}, 32'h01);

        // Ticks with n=3: cmd_seq sampled at edge 1, tick after edges 4, 8, 12.
        do_reset(16'd3);
        cmd_seq = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            check("tick_n3", {31'd0, tick}, (i % 4 == 0) ? 32'd1 : 32'd0);
        end
        cmd_seq = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            check("tick_idle", {31'd0, tick}, 32'd0);
        end
        // Restart: count held n, so first tick again after 4 edges. n changes
        // to 1 after edge 4; the running period still ends at edge 8.
        cmd_seq = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            check("tick_nchg", {31'd0, tick},
                  (i == 4 || i == 8 || i == 10 || i == 12) ? 32'd1 : 32'd0);
            if (i == 4) n = 16'd1;
        end
        // n=0: tick every cycle from the first active edge.
        cmd_seq = 1'b0;
        n = 16'd0;
        step();
        step();
        cmd_seq = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            check("tick_n0", {31'd0, tick}, 32'd1);
        end

        // cmd_delay held high through reset: no edge detected afterwards.
        rst       = 1'b1;
        n         = 16'd0;
        cmd_seq   = 1'b0;
        cmd_delay = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            check("held_through_rst", {31'd0, delay_busy}, 32'd0);
        end

        // Hold with n=0, K=4: time_out 5 edges after capture.
        do_reset(16'd0);
        step();
        step();
        check("cap_lfsr_04", {25'd0, lfsr_out}, 32'h04);
        cmd_delay = 1'b1;
        step();
        check("hold0_busy_cap", {31'd0, delay_busy}, 32'd1);
        check("hold0_to_cap", {31'd0, time_out}, 32'd0);
        for (int i = 1; i <= 7; i++) begin
            step();
            check("hold0_to", {31'd0, time_out}, (i == 5) ? 32'd1 : 32'd0);
            check("hold0_busy", {31'd0, delay_busy}, (i < 5) ? 32'd1 : 32'd0);
        end

        // Scaled hold n=2, K=9: time_out at edge 28; re-pulse mid-hold ignored.
        do_reset(16'd2);
        step();
        step();
        step();
        check("cap_lfsr_09", {25'd0, lfsr_out}, 32'h09);
        cmd_delay = 1'b1;
        step();
        check("hold2_busy_cap", {31'd0, delay_busy}, 32'd1);
        for (int i = 1; i <= 34; i++) begin
            if (i == 5)  cmd_delay = 1'b0;
            if (i == 10) cmd_delay = 1'b1;
            step();
            check("hold2_to", {31'd0, time_out}, (i == 28) ? 32'd1 : 32'd0);
            check("hold2_busy", {31'd0, delay_busy}, (i < 28) ? 32'd1 : 32'd0);
            check("hold2_tick", {31'd0, tick}, 32'd0);
        end

        // Reset mid-hold: hold abandoned, no time_out, LFSR reseeded.
        do_reset(16'd1);
        step();
        cmd_delay = 1'b1;
        step();
        step();
        step();
        check("rsthold_busy_pre", {31'd0, delay_busy}, 32'd1);
        rst = 1'b1;
        step();
        check("rsthold_busy", {31'd0, delay_busy}, 32'd0);
        check("rsthold_to", {31'd0, time_out}, 32'd0);
        check("rsthold_lfsr", {25'd0, lfsr_out}, 32'h01);
        rst = 1'b0;
        cmd_delay = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            check("rsthold_after_to", {31'd0, time_out}, 32'd0);
            check("rsthold_after_busy", {31'd0, delay_busy}, 32'd0);
        end

        // Overlap n=1, K=9: cmd_seq sampled from edge 1; ticks at even edges,
        // time_out at edge 2*9+1 = 19.
        do_reset(16'd1);
        step();
        step();
        step();
        check("ovl_cap_lfsr", {25'd0, lfsr_out}, 32'h09);
        cmd_delay = 1'b1;
        step();
        check("ovl_busy_cap", {31'd0, delay_busy}, 32'd1);
        cmd_seq = 1'b1;
        for (int i = 1; i <= 22; i++) begin
            step();
            check("ovl_tick", {31'd0, tick}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("ovl_to", {31'd0, time_out}, (i == 19) ? 32'd1 : 32'd0);
            check("ovl_busy", {31'd0, delay_busy}, (i < 19) ? 32'd1 : 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
